alu_seq: RTL and testbench

Parametrised, handshaked sequential ALU that replaces the single-cycle combinational ALU in the execute stage. It accepts one operation per valid/ready transfer and returns a registered result with status flags. Single-cycle ops complete in one clock. MUL and DIV run iteratively over WIDTH cycles, so the execute stage stalls on `in_ready`/`out_valid` rather than on a long combinational path.

---
 rtl/alu_seq.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops plus iterative
// shift-add MUL and restoring DIV, one iteration per clock.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [4:0]       aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz,
  output logic             flag_ill,
  output logic             busy
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_NOT  = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_ASR  = 5'd10;
  localparam logic [4:0] OP_MOV  = 5'd11;
  localparam logic [4:0] OP_MOVL = 5'd12;
  localparam logic [4:0] OP_MOVH = 5'd13;

  localparam int             HALF     = WIDTH / 2;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_LIM  = WIDTH'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_flag_z;
  logic             r_flag_n;
  logic             r_flag_c;
  logic             r_flag_v;
  logic             r_flag_dz;
  logic             r_flag_ill;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_iter_start;
  logic             w_sc_load;
  logic             w_last;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_sh;
  logic             w_sh_big;

  logic [WIDTH-1:0] w_sc_res;
  logic             w_sc_c;
  logic             w_sc_v;
  logic             w_sc_dz;
  logic             w_sc_ill;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;

  logic [WIDTH:0]   w_div_sh;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_sub;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  logic             w_ld_en;
  logic [WIDTH-1:0] w_ld_res;
  logic             w_ld_c;
  logic             w_ld_v;
  logic             w_ld_dz;
  logic             w_ld_ill;

  assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flag_z    = r_flag_z;
  assign flag_n    = r_flag_n;
  assign flag_c    = r_flag_c;
  assign flag_v    = r_flag_v;
  assign flag_dz   = r_flag_dz;
  assign flag_ill  = r_flag_ill;

  // A zero divisor is resolved in the accept cycle and never iterates.
  assign w_accept     = in_valid && in_ready;
  assign w_is_mul     = (aluop == OP_MUL);
  assign w_is_div     = (aluop == OP_DIV) && (val2 != '0);
  assign w_iter_start = w_accept && (w_is_mul || w_is_div);
  assign w_sc_load    = w_accept && !(w_is_mul || w_is_div);
  assign w_last       = (r_cnt == CNT_LAST);

  assign w_sum    = {1'b0, val1} + {1'b0, val2};
  assign w_diff   = {1'b0, val1} - {1'b0, val2};
  assign w_sh     = val2[SHW-1:0];
  assign w_sh_big = (val2 >= W_LIM);

  // Shift-add step: r_hi accumulates, r_lo holds the unconsumed multiplier
  // bits and collects the low product bits shifted in from the top.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

  // Restoring step: r_hi is the partial remainder, r_lo shifts the dividend
  // out of its top while quotient bits enter at the bottom.
  assign w_div_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge  = (w_div_sh >= {1'b0, r_b});
  assign w_div_sub = w_div_sh[WIDTH-1:0] - r_b;
  assign w_div_hi  = w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
  assign w_div_lo  = {r_lo[WIDTH-2:0], w_div_ge};

  // Single-cycle result and flag generation from the live operands.
  always_comb begin
    w_sc_res = '0;
    w_sc_c   = 1'b0;
    w_sc_v   = 1'b0;
    w_sc_dz  = 1'b0;
    w_sc_ill = 1'b0;
    case (aluop)
      OP_ADD: begin
        w_sc_res = w_sum[WIDTH-1:0];
        w_sc_c   = w_sum[WIDTH];
        w_sc_v   = (val1[WIDTH-1] == val2[WIDTH-1]) && (w_sum[WIDTH-1] != val1[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_res = w_diff[WIDTH-1:0];
        w_sc_c   = w_diff[WIDTH];
        w_sc_v   = (val1[WIDTH-1] != val2[WIDTH-1]) && (w_diff[WIDTH-1] != val1[WIDTH-1]);
      end
      OP_MUL:  w_sc_res = '0;
      OP_DIV: begin
        w_sc_res = '1;
        w_sc_dz  = 1'b1;
      end
      OP_AND:  w_sc_res = val1 & val2;
      OP_OR:   w_sc_res = val1 | val2;
      OP_NOT:  w_sc_res = ~val2;
      OP_XOR:  w_sc_res = val1 ^ val2;
      OP_SHL:  w_sc_res = w_sh_big ? '0 : (val1 << w_sh);
      OP_SHR:  w_sc_res = w_sh_big ? '0 : (val1 >> w_sh);
      OP_ASR:  w_sc_res = w_sh_big ? {WIDTH{val1[WIDTH-1]}} : WIDTH'($signed(val1) >>> w_sh);
      OP_MOV:  w_sc_res = val1;
      OP_MOVL: w_sc_res = {{HALF{1'b0}}, val2[HALF-1:0]};
      OP_MOVH: w_sc_res = {val2[HALF-1:0], {HALF{1'b0}}};
      default: w_sc_ill = 1'b1;
    endcase
  end

  // Select what, if anything, loads the output registers this cycle.
  always_comb begin
    w_ld_en  = 1'b0;
    w_ld_res = '0;
    w_ld_c   = 1'b0;
    w_ld_v   = 1'b0;
    w_ld_dz  = 1'b0;
    w_ld_ill = 1'b0;
    if (w_sc_load) begin
      w_ld_en  = 1'b1;
      w_ld_res = w_sc_res;
      w_ld_c   = w_sc_c;
      w_ld_v   = w_sc_v;
      w_ld_dz  = w_sc_dz;
      w_ld_ill = w_sc_ill;
    end else if ((r_state == S_MUL) && w_last) begin
      w_ld_en  = 1'b1;
      w_ld_res = w_mul_lo;
      w_ld_c   = (w_mul_hi != '0);
    end else if ((r_state == S_DIV) && w_last) begin
      w_ld_en  = 1'b1;
      w_ld_res = w_div_lo;
    end else begin
      w_ld_en  = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_iter_start) begin
          w_state_nxt = w_is_mul ? S_MUL : S_DIV;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Iteration counter and operand/working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
    end else if (w_iter_start) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= val1;
      r_b   <= val2;
    end else if (r_state == S_MUL) begin
      r_cnt <= w_last ? '0 : (r_cnt + 1'b1);
      r_hi  <= w_mul_hi;
      r_lo  <= w_mul_lo;
    end else if (r_state == S_DIV) begin
      r_cnt <= w_last ? '0 : (r_cnt + 1'b1);
      r_hi  <= w_div_hi;
      r_lo  <= w_div_lo;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Output registers: held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_v    <= 1'b0;
      r_flag_dz   <= 1'b0;
      r_flag_ill  <= 1'b0;
    end else if (w_ld_en) begin
      r_out_valid <= 1'b1;
      r_result    <= w_ld_res;
      r_flag_z    <= (w_ld_res == '0);
      r_flag_n    <= w_ld_res[WIDTH-1];
      r_flag_c    <= w_ld_c;
      r_flag_v    <= w_ld_v;
      r_flag_dz   <= w_ld_dz;
      r_flag_ill  <= w_ld_ill;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq with an arithmetic reference model, a
// per-cycle compare process, and directed literal checks.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] val1 = '0;
  logic [W-1:0] val2 = '0;
  logic [4:0]   aluop = 5'd0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         flag_z, flag_n, flag_c, flag_v, flag_dz, flag_ill, busy;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .val1(val1), .val2(val2), .aluop(aluop), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .flag_v(flag_v), .flag_dz(flag_dz), .flag_ill(flag_ill),
    .busy(busy)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         c, v, dz, ill;
    int           vis;
    logic         iter;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   busy_end = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the op must produce, from plain integer arithmetic.
  function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int now);
    exp_t e;
    longint sa, sb, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.res = '0; e.c = 1'b0; e.v = 1'b0; e.dz = 1'b0; e.ill = 1'b0;
    e.vis = now + 1; e.iter = 1'b0;
    case (op)
      5'd0: begin
        p = 64'(a) + 64'(b); e.res = p[W-1:0]; e.c = p[W];
        sr = sa + sb; e.v = (sr != longint'($signed(sr[31:0])));
      end
      5'd1: begin
        e.res = a - b; e.c = (a < b);
        sr = sa - sb; e.v = (sr != longint'($signed(sr[31:0])));
      end
      5'd2: begin
        p = 64'(a) * 64'(b); e.res = p[W-1:0]; e.c = (p[63:32] != 32'd0);
        e.iter = 1'b1;
      end
      5'd3: begin
        if (b == '0) begin e.res = '1; e.dz = 1'b1; end
        else begin e.res = a / b; e.iter = 1'b1; end
      end
      5'd4: e.res = a & b;
      5'd5: e.res = a | b;
      5'd6: e.res = ~b;
      5'd7: e.res = a ^ b;
      5'd8: if (b >= 32'(W)) e.res = '0; else e.res = a << b;
      5'd9: if (b >= 32'(W)) e.res = '0; else e.res = a >> b;
      5'd10: if (b >= 32'(W)) e.res = {W{a[W-1]}}; else e.res = W'(sa >>> b);
      5'd11: e.res = a;
      5'd12: e.res = b & 32'h0000_FFFF;
      5'd13: e.res = b << 16;
      default: e.ill = 1'b1;
    endcase
    if (e.iter) e.vis = now + 1 + W;
    return e;
  endfunction

  // Compare process: sample mid-cycle, check against model, then record handshakes.
  always begin
    logic exp_ov, exp_busy, exp_rdy;
    exp_t e;
    @(negedge clk);
    #2;
    cyc++;
    if (rst) begin
      q.delete();
      busy_end = 0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_flags", 64'({flag_z, flag_n, flag_c, flag_v, flag_dz, flag_ill}), 64'd0);
    end else begin
      exp_ov   = (q.size() > 0) && (q[0].vis <= cyc);
      exp_busy = (cyc < busy_end);
      exp_rdy  = !exp_busy && (!exp_ov || out_ready);
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (exp_ov && out_valid) begin
        chk("payload",
            64'({result, flag_z, flag_n, flag_c, flag_v, flag_dz, flag_ill}),
            64'({q[0].res, (q[0].res == '0), q[0].res[W-1], q[0].c, q[0].v, q[0].dz, q[0].ill}));
      end
      if (exp_ov && out_ready) void'(q.pop_front());
      if (in_valid && exp_rdy) begin
        e = model(aluop, val1, val2, cyc);
        if (e.iter) busy_end = e.vis;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1; aluop = op; val1 = a; val2 = b;
    #1;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 300) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; aluop = 5'($urandom); val1 = $urandom; val2 = $urandom;
  endtask

  task automatic get_result(input string name, input logic [W-1:0] r,
                            input logic [5:0] fl, input int lat);
    int n;
    n = 1;
    while (!out_valid && n < 200) begin
      @(negedge clk); n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(lat));
    chk(name, 64'({result, flag_z, flag_n, flag_c, flag_v, flag_dz, flag_ill}), 64'({r, fl}));
  endtask

  function automatic logic [W-1:0] rv();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int r;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // flags order: {z, n, c, v, dz, ill}
    send(5'd0, 32'hFFFF_FFFF, 32'd1);   get_result("add_wrap",  32'h0000_0000, 6'b101000, 1);
    send(5'd1, 32'h8000_0000, 32'd1);   get_result("sub_ovf",   32'h7FFF_FFFF, 6'b000100, 1);
    send(5'd10, 32'h8000_0000, 32'd4);  get_result("asr_4",     32'hF800_0000, 6'b010000, 1);
    send(5'd10, 32'h8000_0000, 32'd40); get_result("asr_40",    32'hFFFF_FFFF, 6'b010000, 1);
    send(5'd2, 32'h0001_0000, 32'h0001_0000); get_result("mul_hi", 32'h0000_0000, 6'b101000, W + 1);
    send(5'd3, 32'd100, 32'd7);         get_result("div_100_7", 32'd14,        6'b000000, W + 1);
    send(5'd3, 32'd5, 32'd0);           get_result("div_zero",  32'hFFFF_FFFF, 6'b010010, 1);

    // Backpressure over three streamed XORs.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; aluop = 5'd7; val1 = 32'hF0F0_0000; val2 = 32'h0F0F_1234;
    #1 chk("bp_accept1", 64'(in_ready), 64'd1);
    @(negedge clk);
    val1 = 32'hAAAA_AAAA; val2 = 32'h0000_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_hold_first", 64'(result), 64'h0000_0000_FFFF_1234);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("bp_second", 64'(result), 64'h0000_0000_AAAA_5555);
    val1 = 32'h1234_5678; val2 = 32'h1111_1111;
    @(negedge clk);
    chk("bp_third", 64'(result), 64'h0000_0000_0325_4769);
    chk("bp_third_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Reset in the middle of a division.
    send(5'd3, 32'd1_000_000, 32'd3);
    repeat (8) @(negedge clk);
    chk("busy_mid_div", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    send(5'd13, 32'h0, 32'h0000_1234);  get_result("movh",    32'h1234_0000, 6'b000000, 1);
    send(5'd20, 32'h55, 32'h66);        get_result("illegal", 32'h0000_0000, 6'b100001, 1);

    // Randomized traffic with random consumer stalls.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 8);
      if (r < 7)       aluop = 5'd2;
      else if (r < 14) aluop = 5'd3;
      else if (r < 20) aluop = 5'($urandom_range(14, 31));
      else if (r < 45) aluop = 5'($urandom_range(0, 1));
      else             aluop = 5'($urandom_range(4, 13));
      val1 = rv();
      val2 = rv();
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (W + 5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
